// File: rtl/sonar_bus_pkg.sv
// Shared types and constants for the SonarOnChip local register bus initiator.
package sonar_bus_pkg;

  localparam int BUS_WIDTH = 16;
  localparam int ADR_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_e;

  typedef struct packed {
    logic                 we;
    logic [ADR_WIDTH-1:0] adr;
    logic [BUS_WIDTH-1:0] dat;
  } cmd_t;

  typedef struct packed {
    logic [BUS_WIDTH-1:0] dat;
    logic                 err;
  } rsp_t;

endpackage

// File: rtl/sonar_bus_initiator_if.sv
// Command, response and local-bus signals of the initiator, bundled together.
// master = the initiator itself, slave = everything around it.
interface sonar_bus_initiator_if
  import sonar_bus_pkg::*;
#(
  parameter int BUS_WIDTH = sonar_bus_pkg::BUS_WIDTH,
  parameter int ADR_WIDTH = sonar_bus_pkg::ADR_WIDTH
);
  logic                 cmd_valid_i;
  logic                 cmd_ready_o;
  logic                 cmd_we_i;
  logic [ADR_WIDTH-1:0] cmd_adr_i;
  logic [BUS_WIDTH-1:0] cmd_dat_i;
  logic                 rsp_valid_o;
  logic                 rsp_ready_i;
  logic [BUS_WIDTH-1:0] rsp_dat_o;
  logic                 rsp_err_o;
  logic                 wb_valid_o;
  logic [ADR_WIDTH-1:0] wbs_adr_o;
  logic [BUS_WIDTH-1:0] wbs_dat_o;
  logic                 wbs_strb_o;
  logic                 wbs_ack_i;
  logic [BUS_WIDTH-1:0] wbs_dat_i;
  logic                 stray_ack_o;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, rsp_ready_i, wbs_ack_i, wbs_dat_i,
    output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o, wb_valid_o, wbs_adr_o,
           wbs_dat_o, wbs_strb_o, stray_ack_o
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, rsp_ready_i, wbs_ack_i, wbs_dat_i,
    input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o, wb_valid_o, wbs_adr_o,
           wbs_dat_o, wbs_strb_o, stray_ack_o
  );

endinterface

// File: rtl/sonar_bus_timeout.sv
// Request timeout counter: clear has priority over load, load over count enable.
// expire_o pulses in the enabled cycle where the count reaches TIMEOUT-1;
// TIMEOUT = 0 never expires.
module sonar_bus_timeout
  import sonar_bus_pkg::*;
#(
  parameter int TIMEOUT   = 15,
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_i,
  input  logic                 load_i,
  input  logic [CNT_WIDTH-1:0] load_val_i,
  input  logic                 en_i,
  output logic                 expire_o
);

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(TIMEOUT - 1);

  logic [CNT_WIDTH-1:0] cnt_d, cnt_q;

  // Next count: clear, reload or advance while the request is outstanding.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)       cnt_d = '0;
    else if (load_i) cnt_d = load_val_i;
    else if (en_i)   cnt_d = cnt_q + 1'b1;
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expire_o = (TIMEOUT != 0) && en_i && (cnt_q == LAST);

endmodule

// File: rtl/sonar_bus_initiator.sv
// SonarOnChip local-bus initiator: takes one read/write command at a time,
// drives the registered bus request until ack or timeout, then hands back a
// registered response. All outputs come straight from flops.
module sonar_bus_initiator
  import sonar_bus_pkg::*;
#(
  parameter int BUS_WIDTH = sonar_bus_pkg::BUS_WIDTH,
  parameter int ADR_WIDTH = sonar_bus_pkg::ADR_WIDTH,
  parameter int TIMEOUT   = 15,
  parameter int CNT_WIDTH = 4
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  sonar_bus_initiator_if.master bus
);

  // The command/response structs carry the package widths, so the widths
  // of this instance must agree with them.
  if (BUS_WIDTH != sonar_bus_pkg::BUS_WIDTH || ADR_WIDTH != sonar_bus_pkg::ADR_WIDTH) begin : g_width_chk
    $error("sonar_bus_initiator: widths must match sonar_bus_pkg");
  end
  if ((2 ** CNT_WIDTH) <= TIMEOUT) begin : g_cnt_chk
    $error("sonar_bus_initiator: CNT_WIDTH too small for TIMEOUT");
  end

  state_e state_d, state_q;
  cmd_t   cmd_d, cmd_q;
  rsp_t   rsp_d, rsp_q;
  logic   wb_valid_d, wb_valid_q;
  logic   strb_d, strb_q;
  logic   rsp_valid_d, rsp_valid_q;
  logic   stray_d, stray_q;
  logic   accept, rsp_hs, tmo_expire;

  sonar_bus_timeout #(
    .TIMEOUT   (TIMEOUT),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_timeout (
    .clk        (wb_clk_i),
    .rst        (wb_rst_i),
    .clr_i      (rsp_hs),
    .load_i     (accept),
    .load_val_i ('0),
    .en_i       (state_q == REQ),
    .expire_o   (tmo_expire)
  );

  // Next-state and next-output decode for the single-outstanding transaction.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    rsp_d       = rsp_q;
    wb_valid_d  = wb_valid_q;
    strb_d      = strb_q;
    rsp_valid_d = rsp_valid_q;
    stray_d     = stray_q | (bus.wbs_ack_i && (state_q != REQ));
    accept      = 1'b0;
    rsp_hs      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid_i) begin
          accept     = 1'b1;
          cmd_d.we   = bus.cmd_we_i;
          cmd_d.adr  = bus.cmd_adr_i;
          cmd_d.dat  = bus.cmd_we_i ? bus.cmd_dat_i : '0;
          wb_valid_d = 1'b1;
          strb_d     = bus.cmd_we_i;
          state_d    = REQ;
        end
      end
      REQ: begin
        // Ack is checked first so it wins over a simultaneous timeout.
        if (bus.wbs_ack_i) begin
          rsp_d.dat   = cmd_q.we ? '0 : bus.wbs_dat_i;
          rsp_d.err   = 1'b0;
          wb_valid_d  = 1'b0;
          strb_d      = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end else if (tmo_expire) begin
          rsp_d.dat   = '0;
          rsp_d.err   = 1'b1;
          wb_valid_d  = 1'b0;
          strb_d      = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (bus.rsp_ready_i) begin
          rsp_hs      = 1'b1;
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, bus and response registers; reset drops any pending transaction.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      rsp_q       <= '0;
      wb_valid_q  <= 1'b0;
      strb_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      stray_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      rsp_q       <= rsp_d;
      wb_valid_q  <= wb_valid_d;
      strb_q      <= strb_d;
      rsp_valid_q <= rsp_valid_d;
      stray_q     <= stray_d;
    end
  end

  assign bus.cmd_ready_o = (state_q == IDLE);
  assign bus.wb_valid_o  = wb_valid_q;
  assign bus.wbs_adr_o   = cmd_q.adr;
  assign bus.wbs_dat_o   = cmd_q.dat;
  assign bus.wbs_strb_o  = strb_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_dat_o   = rsp_q.dat;
  assign bus.rsp_err_o   = rsp_q.err;
  assign bus.stray_ack_o = stray_q;

endmodule

// File: tb/tb_sonar_bus_initiator.sv
// Testbench for sonar_bus_initiator: inputs change and outputs are sampled
// on the falling clock edge; responses are checked against a scoreboard.
module tb_sonar_bus_initiator;
  import sonar_bus_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sonar_bus_initiator_if bif ();

  sonar_bus_initiator #(
    .BUS_WIDTH (16),
    .ADR_WIDTH (4),
    .TIMEOUT   (15),
    .CNT_WIDTH (4)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bif.master)
  );

  rsp_t sb[$];
  rsp_t exp_r;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Offer a command until it is taken; returns at the falling edge after acceptance.
  task automatic issue_cmd(input logic we, input logic [3:0] adr, input logic [15:0] dat,
                           output bit ok);
    int n = 0;
    bif.cmd_valid_i = 1'b1;
    bif.cmd_we_i    = we;
    bif.cmd_adr_i   = adr;
    bif.cmd_dat_i   = dat;
    while (!bif.cmd_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    bif.cmd_valid_i = 1'b0;
    ok = (n < 50);
  endtask

  // Wait, bounded, for rsp_valid_o.
  task automatic wait_rsp(output bit got);
    int n = 0;
    while (!bif.rsp_valid_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    got = bif.rsp_valid_o;
  endtask

  // One-cycle ack pulse carrying read data.
  task automatic ack_pulse(input logic [15:0] dat);
    bif.wbs_ack_i = 1'b1;
    bif.wbs_dat_i = dat;
    @(negedge clk);
    bif.wbs_ack_i = 1'b0;
    bif.wbs_dat_i = 16'hDEAD;
  endtask

  task automatic rsp_handshake();
    bif.rsp_ready_i = 1'b1;
    @(negedge clk);
    bif.rsp_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bif.cmd_valid_i = 1'b0; bif.cmd_we_i = 1'b0; bif.cmd_adr_i = '0; bif.cmd_dat_i = '0;
    bif.rsp_ready_i = 1'b0; bif.wbs_ack_i = 1'b0; bif.wbs_dat_i = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bif.wb_valid_o, bif.wbs_strb_o, bif.rsp_valid_o, bif.rsp_err_o, bif.stray_ack_o} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got v/strb/rv/err/stray=%b want 00000",
               {bif.wb_valid_o, bif.wbs_strb_o, bif.rsp_valid_o, bif.rsp_err_o, bif.stray_ack_o});
    end
    n_checks++;
    if ({bif.wbs_adr_o, bif.wbs_dat_o, bif.rsp_dat_o} !== 36'h0) begin
      n_fail++;
      $display("FAIL reset_data: got adr=%h dat=%h rdat=%h want 0", bif.wbs_adr_o, bif.wbs_dat_o, bif.rsp_dat_o);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bif.cmd_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 1", bif.cmd_ready_o);
    end
  endtask

  task automatic test_write();
    bit ok, got;
    sb.push_back('{dat: 16'h0000, err: 1'b0});
    issue_cmd(1'b1, 4'h3, 16'hA5C3, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL write_accept: got no cmd_ready want accept"); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({bif.wb_valid_o, bif.wbs_strb_o, bif.wbs_adr_o, bif.wbs_dat_o, bif.cmd_ready_o, bif.rsp_valid_o}
          !== {1'b1, 1'b1, 4'h3, 16'hA5C3, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL write_bus_c%0d: got v=%b s=%b adr=%h dat=%h rdy=%b rv=%b want 1 1 3 a5c3 0 0", i,
                 bif.wb_valid_o, bif.wbs_strb_o, bif.wbs_adr_o, bif.wbs_dat_o, bif.cmd_ready_o, bif.rsp_valid_o);
      end
      if (i < 2) @(negedge clk);
    end
    ack_pulse(16'hFFFF);
    wait_rsp(got);
    exp_r = sb.pop_front();
    n_checks++;
    if (!got || {bif.rsp_dat_o, bif.rsp_err_o} !== {exp_r.dat, exp_r.err}) begin
      n_fail++;
      $display("FAIL write_rsp: got rv=%b dat=%h err=%b want 1 %h %b", bif.rsp_valid_o, bif.rsp_dat_o,
               bif.rsp_err_o, exp_r.dat, exp_r.err);
    end
    n_checks++;
    if ({bif.wb_valid_o, bif.wbs_strb_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL write_bus_release: got v/s=%b want 00", {bif.wb_valid_o, bif.wbs_strb_o});
    end
    rsp_handshake();
    n_checks++;
    if ({bif.rsp_valid_o, bif.cmd_ready_o} !== 2'b01) begin
      n_fail++;
      $display("FAIL write_done: got rv/rdy=%b want 01", {bif.rsp_valid_o, bif.cmd_ready_o});
    end
  endtask

  task automatic test_read();
    bit ok;
    sb.push_back('{dat: 16'h1234, err: 1'b0});
    issue_cmd(1'b0, 4'h7, 16'hBBBB, ok);
    n_checks++;
    if (!ok || {bif.wb_valid_o, bif.wbs_strb_o, bif.wbs_adr_o, bif.wbs_dat_o} !== {1'b1, 1'b0, 4'h7, 16'h0}) begin
      n_fail++;
      $display("FAIL read_bus: got v=%b s=%b adr=%h dat=%h want 1 0 7 0000", bif.wb_valid_o,
               bif.wbs_strb_o, bif.wbs_adr_o, bif.wbs_dat_o);
    end
    ack_pulse(16'h1234);
    n_checks++;
    if (bif.rsp_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL read_latency: got rsp_valid=%b one cycle after ack want 1", bif.rsp_valid_o);
    end
    exp_r = sb.pop_front();
    n_checks++;
    if ({bif.rsp_dat_o, bif.rsp_err_o} !== {exp_r.dat, exp_r.err}) begin
      n_fail++;
      $display("FAIL read_rsp: got dat=%h err=%b want %h %b", bif.rsp_dat_o, bif.rsp_err_o, exp_r.dat, exp_r.err);
    end
    rsp_handshake();
  endtask

  task automatic test_timeout();
    bit ok, got;
    int n = 0;
    sb.push_back('{dat: 16'h0000, err: 1'b1});
    issue_cmd(1'b0, 4'h1, 16'h0, ok);
    while (bif.wb_valid_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (!ok || n != 15) begin
      n_fail++;
      $display("FAIL timeout_len: got wb_valid cycles=%0d want 15", n);
    end
    wait_rsp(got);
    exp_r = sb.pop_front();
    n_checks++;
    if (!got || {bif.rsp_dat_o, bif.rsp_err_o} !== {exp_r.dat, exp_r.err}) begin
      n_fail++;
      $display("FAIL timeout_rsp: got rv=%b dat=%h err=%b want 1 %h %b", bif.rsp_valid_o, bif.rsp_dat_o,
               bif.rsp_err_o, exp_r.dat, exp_r.err);
    end
    rsp_handshake();
    // Next command: ack lands in the final request cycle, where the timeout would fire.
    sb.push_back('{dat: 16'hBEEF, err: 1'b0});
    issue_cmd(1'b0, 4'h2, 16'h0, ok);
    repeat (14) @(negedge clk);
    n_checks++;
    if (bif.wb_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_edge_valid: got wb_valid=%b in 15th cycle want 1", bif.wb_valid_o);
    end
    ack_pulse(16'hBEEF);
    exp_r = sb.pop_front();
    n_checks++;
    if ({bif.rsp_valid_o, bif.rsp_dat_o, bif.rsp_err_o} !== {1'b1, exp_r.dat, exp_r.err}) begin
      n_fail++;
      $display("FAIL timeout_ack_wins: got rv=%b dat=%h err=%b want 1 %h %b", bif.rsp_valid_o,
               bif.rsp_dat_o, bif.rsp_err_o, exp_r.dat, exp_r.err);
    end
    rsp_handshake();
  endtask

  task automatic test_back_to_back();
    bit ok, got;
    sb.push_back('{dat: 16'h0000, err: 1'b0});
    issue_cmd(1'b1, 4'h2, 16'h5555, ok);
    ack_pulse(16'h0);
    sb.push_back('{dat: 16'h0F0F, err: 1'b0});
    bif.cmd_valid_i = 1'b1; bif.cmd_we_i = 1'b0; bif.cmd_adr_i = 4'h9; bif.cmd_dat_i = 16'h7777;
    exp_r = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({bif.rsp_valid_o, bif.rsp_dat_o, bif.rsp_err_o, bif.cmd_ready_o, bif.wb_valid_o}
          !== {1'b1, exp_r.dat, exp_r.err, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL bp_hold_c%0d: got rv=%b dat=%h err=%b rdy=%b v=%b want 1 %h %b 0 0", i, bif.rsp_valid_o,
                 bif.rsp_dat_o, bif.rsp_err_o, bif.cmd_ready_o, bif.wb_valid_o, exp_r.dat, exp_r.err);
      end
      @(negedge clk);
    end
    rsp_handshake();
    n_checks++;
    if ({bif.cmd_ready_o, bif.rsp_valid_o, bif.wb_valid_o} !== 3'b100) begin
      n_fail++;
      $display("FAIL bp_gap: got rdy/rv/v=%b want 100", {bif.cmd_ready_o, bif.rsp_valid_o, bif.wb_valid_o});
    end
    @(negedge clk);
    bif.cmd_valid_i = 1'b0;
    n_checks++;
    if ({bif.wb_valid_o, bif.wbs_adr_o, bif.wbs_strb_o} !== {1'b1, 4'h9, 1'b0}) begin
      n_fail++;
      $display("FAIL bp_second_cmd: got v=%b adr=%h s=%b want 1 9 0", bif.wb_valid_o, bif.wbs_adr_o, bif.wbs_strb_o);
    end
    ack_pulse(16'h0F0F);
    wait_rsp(got);
    exp_r = sb.pop_front();
    n_checks++;
    if (!got || {bif.rsp_dat_o, bif.rsp_err_o} !== {exp_r.dat, exp_r.err}) begin
      n_fail++;
      $display("FAIL bp_second_rsp: got dat=%h err=%b want %h %b", bif.rsp_dat_o, bif.rsp_err_o, exp_r.dat, exp_r.err);
    end
    rsp_handshake();
  endtask

  task automatic test_stray_ack();
    bit ok, got;
    n_checks++;
    if (bif.stray_ack_o !== 1'b0) begin
      n_fail++;
      $display("FAIL stray_initial: got %b want 0", bif.stray_ack_o);
    end
    ack_pulse(16'h4444);
    repeat (3) begin
      n_checks++;
      if ({bif.stray_ack_o, bif.rsp_valid_o, bif.cmd_ready_o} !== 3'b101) begin
        n_fail++;
        $display("FAIL stray_flag: got stray/rv/rdy=%b want 101", {bif.stray_ack_o, bif.rsp_valid_o, bif.cmd_ready_o});
      end
      @(negedge clk);
    end
    sb.push_back('{dat: 16'hC0DE, err: 1'b0});
    issue_cmd(1'b0, 4'h5, 16'h0, ok);
    ack_pulse(16'hC0DE);
    wait_rsp(got);
    exp_r = sb.pop_front();
    n_checks++;
    if (!got || {bif.rsp_dat_o, bif.rsp_err_o, bif.stray_ack_o} !== {exp_r.dat, exp_r.err, 1'b1}) begin
      n_fail++;
      $display("FAIL stray_read: got dat=%h err=%b stray=%b want %h %b 1", bif.rsp_dat_o, bif.rsp_err_o,
               bif.stray_ack_o, exp_r.dat, exp_r.err);
    end
    rsp_handshake();
  endtask

  task automatic test_reset_mid_req();
    bit ok;
    issue_cmd(1'b1, 4'hA, 16'h1111, ok);
    n_checks++;
    if ({bif.wb_valid_o, bif.wbs_strb_o} !== 2'b11) begin
      n_fail++;
      $display("FAIL midrst_pre: got v/s=%b want 11", {bif.wb_valid_o, bif.wbs_strb_o});
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({bif.wb_valid_o, bif.wbs_strb_o, bif.rsp_valid_o, bif.stray_ack_o, bif.wbs_adr_o} !== 8'h0) begin
      n_fail++;
      $display("FAIL midrst_async: got v/s/rv/stray=%b adr=%h want 0000 0",
               {bif.wb_valid_o, bif.wbs_strb_o, bif.rsp_valid_o, bif.stray_ack_o}, bif.wbs_adr_o);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if ({bif.rsp_valid_o, bif.wb_valid_o, bif.cmd_ready_o} !== 3'b001) begin
        n_fail++;
        $display("FAIL midrst_after_c%0d: got rv/v/rdy=%b want 001", i,
                 {bif.rsp_valid_o, bif.wb_valid_o, bif.cmd_ready_o});
      end
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_back_to_back();
    test_stray_ack();
    test_reset_mid_req();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sonar_bus_initiator.md
Name: sonar_bus_initiator

Overview:
- Initiator side of the SonarOnChip 16-bit local register bus.
- Accepts single read/write commands on a valid/ready command port and drives one bus transaction at a time (valid, address, data, write strobe).
- Waits for the responder's ack, or times out, then returns a response on a valid/ready response port.
- Sits between the management-side bridge or test sequencer and the SonarOnChip register slave.

Parameters:
- BUS_WIDTH, 16, data width of the local bus.
- ADR_WIDTH, 4, address width of the local bus.
- TIMEOUT, 15, cycles in REQ without ack before an error response; 0 disables the timeout (wait forever).
- CNT_WIDTH, 4, width of the timeout counter; must satisfy 2^CNT_WIDTH > TIMEOUT.

Ports:
- wb_clk_i  in  1  bus clock; all logic on the rising edge.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- cmd_valid_i  in  1  command offered.
- cmd_ready_o  out  1  command accepted when high together with cmd_valid_i.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_adr_i  in  ADR_WIDTH  target register address.
- cmd_dat_i  in  BUS_WIDTH  write data; ignored for reads.
- rsp_valid_o  out  1  response available.
- rsp_ready_i  in  1  response consumed.
- rsp_dat_o  out  BUS_WIDTH  read data; 0 for writes and for errors.
- rsp_err_o  out  1  1 = transaction timed out.
- wb_valid_o  out  1  bus request; feeds the slave's wb_valid_i.
- wbs_adr_o  out  ADR_WIDTH  bus address.
- wbs_dat_o  out  BUS_WIDTH  bus write data; feeds the slave's wbs_dat_i.
- wbs_strb_o  out  1  write strobe; feeds the slave's wbs_strb_i.
- wbs_ack_i  in  1  responder ack.
- wbs_dat_i  in  BUS_WIDTH  responder read data; sampled only in the ack cycle.
- stray_ack_o  out  1  sticky flag: an ack arrived outside REQ.

Behaviour:
- Reset values: state IDLE; timeout counter 0; wb_valid_o, wbs_strb_o, rsp_valid_o, rsp_err_o, stray_ack_o = 0; wbs_adr_o, wbs_dat_o, rsp_dat_o = 0. cmd_ready_o = 1 as soon as reset is released, since it is decoded from the IDLE state.
- All bus outputs and response outputs are registered, with no combinational path from inputs to outputs. cmd_ready_o is decoded from the state register only.
- State IDLE:
  - cmd_ready_o = 1.
  - On cmd_valid_i: latch we, adr and dat into the bus output registers and go to REQ.
  - wb_valid_o = 1 and wbs_strb_o = cmd_we_i take effect the next cycle.
  - For a read, wbs_dat_o is driven to 0.
- State REQ:
  - wb_valid_o, wbs_adr_o, wbs_dat_o and wbs_strb_o are held stable; cmd_ready_o = 0.
  - Timeout counter increments every cycle in REQ.
  - If wbs_ack_i = 1: capture rsp_dat_o = wbs_dat_i for a read (0 for a write), set rsp_err_o = 0, deassert wb_valid_o and wbs_strb_o, go to RSP.
  - Else if TIMEOUT != 0 and counter == TIMEOUT-1: set rsp_err_o = 1, rsp_dat_o = 0, deassert the bus signals, go to RSP.
  - If ack and timeout occur in the same cycle, ack wins.
- State RSP:
  - rsp_valid_o = 1; rsp_dat_o and rsp_err_o are held.
  - On rsp_ready_i: rsp_valid_o = 0, counter is cleared, go to IDLE.
  - A new command is accepted no earlier than the cycle after the response handshake, giving at least one idle bus cycle between transactions.
- Latency:
  - Command accepted at cycle N; wb_valid_o is high at N+1.
  - Ack at cycle A (A >= N+1); rsp_valid_o is high at A+1.
  - Minimum command-to-response time is 2 cycles with a same-cycle ack.
- Stray acks: wbs_ack_i = 1 while not in REQ sets stray_ack_o; it is cleared only by reset. The ack is otherwise ignored and the state does not change.
- Reset asserted mid-transaction: every output returns to its reset value asynchronously and the pending command is dropped with no response. The responder must tolerate wb_valid_o falling without an ack.

Decomposition:
- Shared package sonar_bus_pkg holds:
  - BUS_WIDTH and ADR_WIDTH constants.
  - the state enum {IDLE, REQ, RSP}.
  - the command struct {we, adr, dat}.
  - the response struct {dat, err}.
- One natural sub-module: sonar_bus_timeout, a loadable counter with clear, enable and expiry pulse.

Test Plan:
- Write: cmd we=1, adr=4'h3, dat=16'hA5C3; slave acks 2 cycles after valid -> wbs_strb_o=1 and wbs_dat_o=16'hA5C3 stable throughout; rsp_valid_o with rsp_dat_o=0, rsp_err_o=0.
- Read: cmd we=0, adr=4'h7; slave acks with wbs_dat_i=16'h1234 -> wbs_strb_o=0; rsp_dat_o=16'h1234, rsp_err_o=0; rsp_valid_o exactly 1 cycle after the ack.
- Timeout: TIMEOUT=15, slave never acks -> wb_valid_o high for exactly 15 cycles, then rsp_err_o=1 and rsp_dat_o=0; the next command proceeds normally.
- Back-pressure: rsp_ready_i low for 5 cycles, then high; a second cmd_valid_i is held meanwhile -> rsp outputs stable, cmd_ready_o=0 until the cycle after the handshake, then the second command is accepted.
- Reset mid-REQ: assert wb_rst_i while wb_valid_o=1 -> wb_valid_o, wbs_strb_o and rsp_valid_o fall immediately (asynchronously); no response after release; cmd_ready_o=1.
- Stray ack: wbs_ack_i pulsed while in IDLE -> stray_ack_o=1 and stays set; no rsp_valid_o; a subsequent read completes normally.
